// File: rtl/mmio_timer_pwm.sv
// MMIO peripheral: 3-channel LED PWM, micros/millis counters and ID word in an 8-word window.
// Define MMIO_WDT_EN to add the watchdog down-counter at offset 0x18 and drive wdt_bite.
module mmio_timer_pwm #(
    parameter logic [31:0] BASE_ADDR      = 32'hFFFF_FFE0,
    parameter int          CLK_HZ         = 12_000_000,
    parameter bit          LED_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        write_mem,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    input  logic [31:0] read_address,
    output logic [31:0] read_data,
    output logic        read_hit,
    output logic [2:0]  pwm_out,
    output logic        wdt_bite
);
    localparam int             US_DIV  = CLK_HZ / 1_000_000;
    localparam int             USW     = $clog2(US_DIV);
    localparam logic [USW-1:0] US_LAST = USW'(US_DIV - 1);
    localparam logic [31:0]    ID_WORD = 32'h4D4D_494F;

    logic            wr_hit, rd_hit;
    logic [2:0]      wr_off;
    logic [2:0][7:0] shadow_q, shadow_d, duty_q, duty_d;
    logic [1:0]      ctrl_q, ctrl_d;
    logic [7:0]      pwm_cnt_q;
    logic [2:0]      pwm_q, pwm_d;
    logic [USW-1:0]  us_pre_q, us_pre_d;
    logic [9:0]      ms_pre_q, ms_pre_d;
    logic [31:0]     micros_q, micros_d, millis_q, millis_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            rhit_q;
`ifdef MMIO_WDT_EN
    logic [31:0]     wdt_q, wdt_d;
    logic            armed_q, armed_d, bite_q, bite_d;
`endif

    assign wr_hit = write_mem && (write_address[31:5] == BASE_ADDR[31:5]);
    assign wr_off = write_address[4:2];
    assign rd_hit = read_address[31:5] == BASE_ADDR[31:5];

    always_comb begin
        shadow_d = shadow_q;
        duty_d   = duty_q;
        ctrl_d   = ctrl_q;
        us_pre_d = us_pre_q;
        ms_pre_d = ms_pre_q;
        micros_d = micros_q;
        millis_d = millis_q;
        if (wr_hit) begin
            case (wr_off)
                3'd0:    shadow_d[0] = write_data[7:0];
                3'd1:    shadow_d[1] = write_data[7:0];
                3'd2:    shadow_d[2] = write_data[7:0];
                3'd3:    ctrl_d      = write_data[1:0];
                default: ;
            endcase
        end
        // Active duty only changes at the period boundary so no channel sees a runt pulse.
        if (pwm_cnt_q == 8'hFF) duty_d = shadow_q;
        for (int i = 0; i < 3; i++)
            pwm_d[i] = (ctrl_q[0] && (pwm_cnt_q < duty_q[i])) ^ LED_ACTIVE_LOW;
        if (!ctrl_q[1]) begin
            if (us_pre_q == US_LAST) begin
                us_pre_d = '0;
                micros_d = micros_q + 32'd1;
                if (ms_pre_q == 10'd999) begin
                    ms_pre_d = '0;
                    millis_d = millis_q + 32'd1;
                end else begin
                    ms_pre_d = ms_pre_q + 10'd1;
                end
            end else begin
                us_pre_d = us_pre_q + 1'b1;
            end
        end
`ifdef MMIO_WDT_EN
        wdt_d   = wdt_q;
        armed_d = armed_q;
        bite_d  = 1'b0;
        // A write in the expiry cycle reloads and suppresses the bite.
        if (wr_hit && wr_off == 3'd6) begin
            wdt_d   = write_data;
            armed_d = write_data != 32'd0;
        end else if (armed_q) begin
            wdt_d = wdt_q - 32'd1;
            if (wdt_q == 32'd1) begin
                bite_d  = 1'b1;
                armed_d = 1'b0;
            end
        end
`endif
        rdata_d = '0;
        if (rd_hit) begin
            case (read_address[4:2])
                3'd0: rdata_d = {24'h0, shadow_q[0]};
                3'd1: rdata_d = {24'h0, shadow_q[1]};
                3'd2: rdata_d = {24'h0, shadow_q[2]};
                3'd3: rdata_d = {30'h0, ctrl_q};
                3'd4: rdata_d = micros_q;
                3'd5: rdata_d = millis_q;
`ifdef MMIO_WDT_EN
                3'd6: rdata_d = wdt_q;
`else
                3'd6: rdata_d = '0;
`endif
                default: rdata_d = ID_WORD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            duty_q    <= '0;
            ctrl_q    <= 2'b01;
            pwm_cnt_q <= '0;
            pwm_q     <= {3{LED_ACTIVE_LOW}};
            us_pre_q  <= '0;
            ms_pre_q  <= '0;
            micros_q  <= '0;
            millis_q  <= '0;
            rdata_q   <= '0;
            rhit_q    <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            duty_q    <= duty_d;
            ctrl_q    <= ctrl_d;
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
            pwm_q     <= pwm_d;
            us_pre_q  <= us_pre_d;
            ms_pre_q  <= ms_pre_d;
            micros_q  <= micros_d;
            millis_q  <= millis_d;
            rdata_q   <= rdata_d;
            rhit_q    <= rd_hit;
        end
    end

`ifdef MMIO_WDT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_q   <= '0;
            armed_q <= 1'b0;
            bite_q  <= 1'b0;
        end else begin
            wdt_q   <= wdt_d;
            armed_q <= armed_d;
            bite_q  <= bite_d;
        end
    end
    assign wdt_bite = bite_q;
`else
    assign wdt_bite = 1'b0;
`endif

    assign read_data = rdata_q;
    assign read_hit  = rhit_q;
    assign pwm_out   = pwm_q;
endmodule

// File: tb/tb_mmio_timer_pwm.sv
// Directed bench for mmio_timer_pwm; bus reads are checked by a queue-based scoreboard monitor.
module tb_mmio_timer_pwm;
    localparam logic [31:0] BASE = 32'hFFFF_FFE0;
    localparam logic [31:0] IDW  = 32'h4D4D_494F;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        write_mem = 1'b0;
    logic [31:0] write_address = '0, write_data = '0, read_address = '0;
    logic [31:0] read_data;
    logic        read_hit;
    logic [2:0]  pwm_out;
    logic        wdt_bite;

    typedef struct {
        logic [31:0] d;
        logic        h;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0, n_err = 0, cyc = 0;
    logic rd_en = 1'b0, rd_pend = 1'b0;

    mmio_timer_pwm dut (
        .clk(clk), .rst_n(rst_n), .write_mem(write_mem), .write_address(write_address),
        .write_data(write_data), .read_address(read_address), .read_data(read_data),
        .read_hit(read_hit), .pwm_out(pwm_out), .wdt_bite(wdt_bite)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc     <= 0;
            rd_pend <= 1'b0;
        end else begin
            cyc     <= cyc + 1;
            rd_pend <= rd_en;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one registered response appears the cycle after each issued read.
    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_read: got %h expected none", read_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, ".data"}, read_data, e.d);
                chk({e.name, ".hit"}, {31'h0, read_hit}, {31'h0, e.h});
            end
        end
    end

    // All bus tasks start and end just after a falling edge.
    task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic h, input string nm);
        exp_t e;
        e.d = d; e.h = h; e.name = nm;
        exp_q.push_back(e);
        read_address = a;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        write_mem = 1'b1; write_address = a; write_data = d;
        @(negedge clk);
        write_mem = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int lows, first_low, other_hi, bites;
        // Reset
        repeat (3) @(negedge clk);
        chk("rst.read_data", read_data, 32'h0);
        chk("rst.read_hit", {31'h0, read_hit}, 32'h0);
        chk("rst.pwm_out", {29'h0, pwm_out}, 32'h7);
        chk("rst.wdt_bite", {31'h0, wdt_bite}, 32'h0);
        rst_n = 1'b1;
        rd(BASE + 32'h0C, 32'h1, 1'b1, "ctrl_reset");
        rd(BASE + 32'h1C, IDW, 1'b1, "id");

        // Counters: 12000 edges since release, freeze lands on edge 12000
        while (cyc != 11999) @(negedge clk);
        wr(BASE + 32'h0C, 32'h3);
        rd(BASE + 32'h10, 32'd1000, 1'b1, "micros_12k");
        rd(BASE + 32'h14, 32'd1, 1'b1, "millis_12k");
        repeat (500) @(negedge clk);
        rd(BASE + 32'h10, 32'd1000, 1'b1, "micros_frozen");
        rd(BASE + 32'h14, 32'd1, 1'b1, "millis_frozen");

        // PWM: write mid-period, nothing changes until the wrap
        while (cyc % 256 != 100) @(negedge clk);
        wr(BASE, 32'h40);
        lows = 0;
        while (cyc % 256 != 0) begin
            if (!pwm_out[0]) lows++;
            @(negedge clk);
        end
        if (!pwm_out[0]) lows++;
        chk("pwm_pre_wrap_lows", lows, 0);
        lows = 0; first_low = 0; other_hi = 1;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (!pwm_out[0]) lows++;
            if (i == 0) first_low = !pwm_out[0];
            if (pwm_out[2:1] != 2'b11) other_hi = 0;
        end
        chk("pwm_duty40_lows", lows, 64);
        chk("pwm_first_low", first_low, 1);
        chk("pwm_other_off", other_hi, 1);
        rd(BASE, 32'h40, 1'b1, "duty0_rb");
        wr(BASE, 32'h0);
        repeat (512) @(negedge clk);
        lows = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (!pwm_out[0]) lows++;
        end
        chk("pwm_duty0_lows", lows, 0);

        // MICROS wrap via deposit
        wr(BASE + 32'h0C, 32'h1);
        dut.micros_q = 32'hFFFF_FFFF;
        repeat (12) @(negedge clk);
        rd(BASE + 32'h10, 32'h0, 1'b1, "micros_wrap");

        // Same-cycle read/write, then miss and RO write
        exp_q.push_back('{d: 32'h0, h: 1'b1, name: "duty0_rw_old"});
        read_address = BASE; rd_en = 1'b1;
        write_mem = 1'b1; write_address = BASE; write_data = 32'hFFFF_FFAA;
        @(negedge clk);
        rd_en = 1'b0; write_mem = 1'b0;
        rd(BASE, 32'hAA, 1'b1, "duty0_new");
        rd(BASE - 32'h4, 32'h0, 1'b0, "miss_below");
        wr(BASE + 32'h1C, 32'h0);
        wr(BASE - 32'h20, 32'h55);
        rd(BASE + 32'h1C, IDW, 1'b1, "id_ro");
        rd(BASE, 32'hAA, 1'b1, "duty0_oow_write");

`ifdef MMIO_WDT_EN
        wr(BASE + 32'h18, 32'd5);
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            chk($sformatf("wdt_bite_t%0d", j), {31'h0, wdt_bite}, {31'h0, j == 5});
        end
        bites = 0;
        repeat (6) begin
            wr(BASE + 32'h18, 32'd5);
            repeat (2) begin
                if (wdt_bite) bites++;
                @(negedge clk);
            end
            if (wdt_bite) bites++;
        end
        chk("wdt_kick_bites", bites, 0);
        wr(BASE + 32'h18, 32'd0);
        bites = 0;
        repeat (10) begin
            @(negedge clk);
            if (wdt_bite) bites++;
        end
        chk("wdt_disarm_bites", bites, 0);
        rd(BASE + 32'h18, 32'h0, 1'b1, "wdt_disarmed");
`else
        wr(BASE + 32'h18, 32'd5);
        bites = 0;
        repeat (10) begin
            @(negedge clk);
            if (wdt_bite) bites++;
        end
        chk("wdt_absent_bites", bites, 0);
        rd(BASE + 32'h18, 32'h0, 1'b1, "wdt_absent_read");
`endif

        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
